// File: rtl/store_buffer.sv
// store_buffer: word-addressed write buffer between MEM stage and data memory; optional forwarding via STORE_BUFFER_FORWARD_EN
//   st_valid/st_ready/st_addr/st_data : store enqueue handshake from the pipeline
//   ld_req/ld_addr/ld_data/ld_hit/ld_stall : zero-latency load path with pending-store check
//   mem_write/mem_read/mem_addr/mem_wdata/mem_rdata : shared single-port memory interface
//   count/empty/full : occupancy status
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic                       ld_req,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       ld_hit,
  output logic                       ld_stall,
  output logic                       mem_write,
  output logic                       mem_read,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WA = ADDR_W - 2;
  logic [WA-1:0]     e_addr [DEPTH];
  logic [DATA_W-1:0] e_data [DEPTH];
  logic [PW-1:0]     head, tail, idx;
  logic              match, enq;
  logic [DATA_W-1:0] fwd;
  logic              unused_lo;
  assign unused_lo = ^st_addr[1:0];
  // scan oldest to youngest so the last match seen is the youngest
  always_comb begin
    match = 1'b0;
    fwd   = '0;
    idx   = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count && e_addr[idx] == ld_addr[ADDR_W-1:2]) begin
        match = 1'b1;
        fwd   = e_data[idx];
      end
    end
  end
`ifdef STORE_BUFFER_FORWARD_EN
  assign ld_hit   = ld_req & match;
  assign ld_stall = 1'b0;
`else
  assign ld_hit   = 1'b0;
  assign ld_stall = ld_req & match;
`endif
  assign empty     = count == '0;
  assign full      = count == CW'(DEPTH);
  assign st_ready  = ~full;
  assign mem_read  = ld_req & ~ld_hit & ~ld_stall;
  assign mem_write = ~mem_read & ~empty;
  assign mem_addr  = mem_read ? ld_addr : {e_addr[head], 2'b00};
  assign mem_wdata = e_data[head];
  assign ld_data   = ld_hit ? fwd : mem_read ? mem_rdata : '0;
  assign enq       = st_valid & ~full;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
      end
    end else begin
      if (enq) begin
        e_addr[tail] <= st_addr[ADDR_W-1:2];
        e_data[tail] <= st_data;
        tail         <= tail + 1'b1;
      end
      if (mem_write) head <= head + 1'b1;
      count <= count + CW'(enq) - CW'(mem_write);
    end
  end
endmodule
